accumulator_bank: RTL and testbench
===================================

// Module: accumulator_bank
// PURPOSE
//  Multi-column partial-sum buffer behind the systolic array. Each column stores DEPTH result rows.
//  Each incoming word either overwrites or accumulates into its row, which supports K-tiled matmul.
//  Drains completed rows to unified-buffer writeback over a valid/ready stream, clearing each row as it is read.
// PARAMETERS
//  N_COLS   4   number of independent columns (systolic array width)
//  DEPTH    4   rows stored per column; power of two, >=2
//  IN_W     16  signed input width from the array
//  ACC_W    32  signed accumulator width; ACC_W >= IN_W (elaboration-time check)
// PORTS
//  clk         in   1             clock
//  reset       in   1             synchronous, active-low reset
//  in_valid    in   N_COLS        per-column write strobe (skewed arrival is allowed)
//  in_data     in   N_COLS*IN_W   column c at [c*IN_W +: IN_W], signed
//  acc_mode    in   1             0 = overwrite, 1 = accumulate; sampled with each write
//  drain_start in   1             request readout of all DEPTH rows
//  out_valid   out  1             out_data holds a row
//  out_ready   in   1             downstream accepts the row
//  out_data    out  N_COLS*ACC_W  row rd_ptr; column c at [c*ACC_W +: ACC_W]
//  out_last    out  1             high with row DEPTH-1
//  full        out  1             every column has written DEPTH rows since the last clear
//  drop_err    out  1             sticky: a write arrived in DRAIN; cleared only by reset
//  sat_flag    out  N_COLS        sticky per column: saturation occurred (tied 0 without macro)
// BEHAVIOUR
//  Reset (reset==0 at posedge): all mem=0, wp[c]=0, done[c]=0, rd_ptr=0, state=FILL.
//   All outputs are 0. Reset applies mid-drain too; out_valid is 0 the following cycle.
//  FSM: FILL -> DRAIN on drain_start. DRAIN -> FILL on the handshake of row DEPTH-1.
//  FILL: for each c with in_valid[c], at the posedge: x = sign-extend(in_data[c]) to ACC_W.
//   mem[wp[c]][c] <= acc_mode ? mem[wp[c]][c] + x : x.
//   wp[c] increments; at DEPTH-1 it wraps to 0 and sets done[c].
//   Zero-valued inputs are ordinary data and are always written.
//  full = &done. Writes continue after full; wp keeps wrapping, which allows multi-pass accumulation.
//  drain_start in FILL: the same-cycle writes complete, then DRAIN begins next cycle with rd_ptr=0.
//   drain_start is ignored while in DRAIN.
//  DRAIN: out_valid=1. out_data is a combinational read of mem[rd_ptr].
//   out_data must stay stable until handshake (out_valid&&out_ready).
//   On handshake: row rd_ptr <= 0 and rd_ptr++.
//   The last handshake also sets wp=0, done=0 and state=FILL; out_valid drops the next cycle.
//  in_valid during DRAIN: the write is discarded and drop_err is set.
//  Throughput: 1 row/cycle with out_ready held high; drain latency is DEPTH cycles.
//   Zero bubble between the last row and the next FILL write.
//  Arithmetic: two's complement, ACC_W bits, wrap-around on overflow (default).
// CONFIGURATION
//  ACCUMULATOR_BANK_SATURATE_EN defined:
//   Accumulate clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
//   Any clamp sets sat_flag[c], which is cleared by reset or at drain completion.
//  ACCUMULATOR_BANK_SATURATE_EN undefined: modulo-2^ACC_W wrap; sat_flag is constant 0.
// STRUCTURE
//  Package tpu_acc_pkg:
//   acc_state_t enum {FILL, DRAIN}.
//   Default-width localparams (ACC_IN_W, ACC_OUT_W).
//   Function sat_add(a, b) returning {sat, sum}.
//  Sub-module acc_column, generated N_COLS times: DEPTH x ACC_W storage, wp/done, adder, optional saturation.
//  Top level holds the FSM, rd_ptr, row clear strobe, flag reduction and output mux.
// TESTING  (N_COLS=2, DEPTH=4, IN_W=16, ACC_W=32)
//  1 Overwrite fill: both columns write 1,2,3,4 (mode 0) -> full=1.
//    Then drain with ready=1 -> rows {1,1},{2,2},{3,3},{4,4}; out_last on the 4th; mem all 0 after.
//  2 Two-pass accumulate: pass 1 writes 5 (mode 0), pass 2 writes -7 (mode 1), 4 rows x 2 cols.
//    -> drained every row = -2 (0xFFFFFFFE); zero-valued inputs are stored.
//  3 Skew/backpressure: col1 lags col0 by 2 cycles; full only after col1's 4th write.
//    Drain with out_ready toggling 1,0,0,1 -> out_data held while stalled; no row lost or duplicated.
//  4 Collisions: in_valid=2'b11 together with drain_start -> the write lands and drain starts next cycle.
//    in_valid during DRAIN -> data dropped, drop_err=1.
//  5 Reset (reset=0) mid-drain after 2 rows -> next cycle out_valid=0, full=0, state FILL.
//    A fresh fill of 9s drains as 9s.
//  6 Macro on: accumulate 0x7FFFFFF0 + 0x0100 -> 0x7FFFFFFF, sat_flag[c]=1.
//    Macro off: the same stimulus gives 0x800000F0 and sat_flag=0.

Source files
------------

// File: rtl/tpu_acc_pkg.sv
// ---------------------------------------------------------------------------
// tpu_acc_pkg
// Shared types, default widths and arithmetic helpers for the accumulator
// bank that sits behind the systolic array.
//
// Contents:
//   acc_state_t  - bank state: FILL (columns accept writes) / DRAIN (rows
//                  stream out to writeback)
//   ACC_IN_W     - default signed input width from the array
//   ACC_OUT_W    - default signed accumulator width
//   ACC_MAX_W    - widest accumulator sat_add can handle
//   sat_add()    - signed add clamped to a w-bit two's complement range,
//                  returns {sat, sum}
//
// Used by the optional saturating build (ACCUMULATOR_BANK_SATURATE_EN).
// ---------------------------------------------------------------------------
package tpu_acc_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } acc_state_t;

  localparam int ACC_IN_W  = 16;
  localparam int ACC_OUT_W = 32;
  localparam int ACC_MAX_W = 64;

  // Operands must already be sign-extended from w bits to ACC_MAX_W bits.
  // The add is done one bit wider so the true sum is never lost, then it is
  // compared against the w-bit signed limits. Bit ACC_MAX_W of the result is
  // the "clamped" flag; the low w bits hold the (possibly clamped) sum.
  function automatic logic [ACC_MAX_W:0] sat_add(
    input logic [ACC_MAX_W-1:0] a,
    input logic [ACC_MAX_W-1:0] b,
    input int                   w
  );
    logic signed [ACC_MAX_W:0] sum;
    logic signed [ACC_MAX_W:0] hi;
    logic signed [ACC_MAX_W:0] lo;
    logic [ACC_MAX_W:0]        res;
    sum = $signed({a[ACC_MAX_W-1], a}) + $signed({b[ACC_MAX_W-1], b});
    hi  = (65'sd1 <<< (w - 1)) - 65'sd1;
    lo  = -(65'sd1 <<< (w - 1));
    if (sum > hi) begin
      res = {1'b1, hi[ACC_MAX_W-1:0]};
    end else if (sum < lo) begin
      res = {1'b1, lo[ACC_MAX_W-1:0]};
    end else begin
      res = {1'b0, sum[ACC_MAX_W-1:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/acc_column.sv
// ---------------------------------------------------------------------------
// acc_column
// One column of the accumulator bank: DEPTH rows of ACC_W-bit signed
// storage, a write pointer that walks the rows round-robin, a done flag set
// when the pointer wraps, and the overwrite/accumulate adder.
//
// Ports:
//   clk, reset    - clock, synchronous active-low reset
//   wr_en_i       - write strobe (already gated to FILL by the top)
//   wr_data_i     - signed input word, IN_W bits
//   acc_mode_i    - 0 = overwrite row, 1 = add into row
//   rd_idx_i      - row presented on rd_data_o, also the row cleared by
//                   clr_row_i
//   clr_row_i     - zero row rd_idx_i (row handshake during drain)
//   clr_all_i     - drain finished: rewind wp, drop done, drop sat flag
//   rd_data_o     - combinational read of row rd_idx_i
//   done_o        - this column has written all DEPTH rows since last clear
//   sat_o         - sticky saturation flag (constant 0 unless
//                   ACCUMULATOR_BANK_SATURATE_EN is defined)
//
// Configuration: define ACCUMULATOR_BANK_SATURATE_EN for clamping adds;
// otherwise the add wraps modulo 2^ACC_W.
// ---------------------------------------------------------------------------
module acc_column
  import tpu_acc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IN_W  = ACC_IN_W,
  parameter int ACC_W = ACC_OUT_W,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [IN_W-1:0]  wr_data_i,
  input  logic             acc_mode_i,
  input  logic [AW-1:0]    rd_idx_i,
  input  logic             clr_row_i,
  input  logic             clr_all_i,
  output logic [ACC_W-1:0] rd_data_o,
  output logic             done_o,
  output logic             sat_o
);

  logic [ACC_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q;
  logic [AW-1:0]    wp_d;
  logic             done_q;
  logic             done_d;
  logic [ACC_W-1:0] ext_data;
  logic [ACC_W-1:0] cur_row;
  logic [ACC_W-1:0] wr_val;

  assign ext_data  = ACC_W'($signed(wr_data_i));
  assign cur_row   = mem_q[wp_q];
  assign rd_data_o = mem_q[rd_idx_i];
  assign done_o    = done_q;

`ifdef ACCUMULATOR_BANK_SATURATE_EN
  logic [ACC_MAX_W:0] sat_res;
  logic               sat_q;
  logic               sat_d;

  if (ACC_W > ACC_MAX_W) begin : g_chk_sat_w
    $error("acc_column: saturating build supports ACC_W up to ACC_MAX_W");
  end

  assign sat_res = sat_add(ACC_MAX_W'($signed(cur_row)),
                           ACC_MAX_W'($signed(ext_data)), ACC_W);
  assign wr_val  = acc_mode_i ? sat_res[ACC_W-1:0] : ext_data;
  assign sat_o   = sat_q;

  // The saturation flag is sticky across writes; it only falls when a
  // drain completes (the accumulated results have been handed off) or on
  // reset. A clamp on an overwrite is impossible, so only accumulates count.
  always_comb begin
    sat_d = sat_q;
    if (clr_all_i) begin
      sat_d = 1'b0;
    end else if (wr_en_i && acc_mode_i && sat_res[ACC_MAX_W]) begin
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end
`else
  assign wr_val = acc_mode_i ? (cur_row + ext_data) : ext_data;
  assign sat_o  = 1'b0;
`endif

  // Write pointer walks the rows round-robin. DEPTH is a power of two so
  // the increment wraps on its own; the wrap is also where done is set.
  // Writes keep going after done so several passes can accumulate into the
  // same rows (K-tiling).
  always_comb begin
    wp_d   = wp_q;
    done_d = done_q;
    if (clr_all_i) begin
      wp_d   = '0;
      done_d = 1'b0;
    end else if (wr_en_i) begin
      wp_d = wp_q + 1'b1;
      if (wp_q == AW'(DEPTH - 1)) begin
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wp_q   <= '0;
      done_q <= 1'b0;
    end else begin
      wp_q   <= wp_d;
      done_q <= done_d;
    end
  end

  // Row storage. The top only writes in FILL and only clears in DRAIN, so
  // the two ports never hit the same cycle; if they ever did, the write wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_q[r] <= '0;
      end
    end else begin
      if (clr_row_i) begin
        mem_q[rd_idx_i] <= '0;
      end
      if (wr_en_i) begin
        mem_q[wp_q] <= wr_val;
      end
    end
  end

endmodule

// File: rtl/accumulator_bank.sv
// ---------------------------------------------------------------------------
// accumulator_bank
// Multi-column partial-sum buffer behind the systolic array. Each column
// holds DEPTH rows; every incoming word overwrites or accumulates into the
// column's current row. A drain streams all rows out over valid/ready,
// zeroing each row as it is accepted.
//
// Ports:
//   clk          in   clock
//   reset        in   synchronous, active-low reset
//   in_valid     in   [N_COLS]         per-column write strobe (may be skewed)
//   in_data      in   [N_COLS*IN_W]    column c at [c*IN_W +: IN_W], signed
//   acc_mode     in   0 = overwrite, 1 = accumulate
//   drain_start  in   start readout of all rows (ignored while draining)
//   out_valid    out  out_data holds a row
//   out_ready    in   downstream accepts the row
//   out_data     out  [N_COLS*ACC_W]   column c at [c*ACC_W +: ACC_W]
//   out_last     out  high with row DEPTH-1
//   full         out  every column has written DEPTH rows since last clear
//   drop_err     out  sticky: a write arrived while draining
//   sat_flag     out  [N_COLS] sticky per-column saturation flag
//
// Configuration: `ACCUMULATOR_BANK_SATURATE_EN` selects clamping adds with
// live sat_flag; without it adds wrap and sat_flag is constant 0.
// ---------------------------------------------------------------------------
module accumulator_bank
  import tpu_acc_pkg::*;
#(
  parameter int N_COLS = 4,
  parameter int DEPTH  = 4,
  parameter int IN_W   = ACC_IN_W,
  parameter int ACC_W  = ACC_OUT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_COLS-1:0]       in_valid,
  input  logic [N_COLS*IN_W-1:0]  in_data,
  input  logic                    acc_mode,
  input  logic                    drain_start,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_COLS*ACC_W-1:0] out_data,
  output logic                    out_last,
  output logic                    full,
  output logic                    drop_err,
  output logic [N_COLS-1:0]       sat_flag
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (ACC_W < IN_W) begin : g_chk_width
    $error("accumulator_bank: ACC_W must be >= IN_W");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
    $error("accumulator_bank: DEPTH must be a power of two >= 2");
  end

  acc_state_t        state_q;
  acc_state_t        state_d;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW-1:0]     rd_ptr_d;
  logic              drop_err_q;
  logic              drop_err_d;
  logic              fill_en;
  logic              row_hs;
  logic              last_row;
  logic              drain_done;
  logic [N_COLS-1:0] done_vec;
  logic [N_COLS-1:0] sat_vec;

  assign fill_en    = (state_q == FILL);
  assign last_row   = (rd_ptr_q == AW'(DEPTH - 1));
  assign row_hs     = (state_q == DRAIN) && out_ready;
  assign drain_done = row_hs && last_row;

  assign out_valid  = (state_q == DRAIN);
  assign out_last   = (state_q == DRAIN) && last_row;
  assign full       = &done_vec;
  assign drop_err   = drop_err_q;
  assign sat_flag   = sat_vec;

  // One column instance per array column. All columns share the read
  // pointer, the row-clear strobe and the drain-complete strobe, so the
  // output row is simply the concatenation of every column's read port.
  for (genvar c = 0; c < N_COLS; c++) begin : g_col
    acc_column #(
      .DEPTH (DEPTH),
      .IN_W  (IN_W),
      .ACC_W (ACC_W),
      .AW    (AW)
    ) u_col (
      .clk        (clk),
      .reset      (reset),
      .wr_en_i    (fill_en && in_valid[c]),
      .wr_data_i  (in_data[c*IN_W +: IN_W]),
      .acc_mode_i (acc_mode),
      .rd_idx_i   (rd_ptr_q),
      .clr_row_i  (row_hs),
      .clr_all_i  (drain_done),
      .rd_data_o  (out_data[c*ACC_W +: ACC_W]),
      .done_o     (done_vec[c]),
      .sat_o      (sat_vec[c])
    );
  end

  // Bank FSM. drain_start is only honoured in FILL; writes presented in that
  // same cycle still land because the columns see fill_en until the edge.
  // In DRAIN each accepted row advances rd_ptr, and accepting the last row
  // drops straight back to FILL so a write can land the very next cycle.
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    case (state_q)
      FILL: begin
        if (drain_start) begin
          state_d  = DRAIN;
          rd_ptr_d = '0;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          if (last_row) begin
            state_d = FILL;
          end
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // Writes arriving while draining are thrown away; drop_err remembers that
  // it happened until the next reset so software can notice a bad schedule.
  always_comb begin
    drop_err_d = drop_err_q;
    if ((state_q == DRAIN) && (|in_valid)) begin
      drop_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= FILL;
      rd_ptr_q   <= '0;
      drop_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      drop_err_q <= drop_err_d;
    end
  end

endmodule

// File: tb/tb_accumulator_bank.sv
// ---------------------------------------------------------------------------
// tb_accumulator_bank
// Bench for accumulator_bank (N_COLS=2, DEPTH=4, IN_W=16, ACC_W=32) plus a
// second instance with IN_W=32 so accumulator limits can be reached in a
// handful of writes. A bench-side model tracks the rows; drained rows are
// queued at drain start and compared by a monitor on every cycle out_valid
// is high (which also catches data changing while stalled).
// ---------------------------------------------------------------------------
module tb_accumulator_bank;

  localparam int N  = 2;
  localparam int D  = 4;
  localparam int IW = 16;
  localparam int AW = 32;

  logic            clk;
  logic            reset;
  logic [N-1:0]    in_valid;
  logic [N*IW-1:0] in_data;
  logic            acc_mode;
  logic            drain_start;
  logic            out_valid;
  logic            out_ready;
  logic [N*AW-1:0] out_data;
  logic            out_last;
  logic            full;
  logic            drop_err;
  logic [N-1:0]    sat_flag;

  logic [N-1:0]    w_in_valid;
  logic [N*AW-1:0] w_in_data;
  logic            w_acc_mode;
  logic            w_drain_start;
  logic            w_out_valid;
  logic            w_out_ready;
  logic [N*AW-1:0] w_out_data;
  logic            w_out_last;
  logic            w_full;
  logic            w_drop_err;
  logic [N-1:0]    w_sat_flag;

  accumulator_bank #(.N_COLS(N), .DEPTH(D), .IN_W(IW), .ACC_W(AW)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .acc_mode(acc_mode), .drain_start(drain_start), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .full(full), .drop_err(drop_err), .sat_flag(sat_flag)
  );

  accumulator_bank #(.N_COLS(N), .DEPTH(D), .IN_W(AW), .ACC_W(AW)) u_wide (
    .clk(clk), .reset(reset), .in_valid(w_in_valid), .in_data(w_in_data),
    .acc_mode(w_acc_mode), .drain_start(w_drain_start), .out_valid(w_out_valid),
    .out_ready(w_out_ready), .out_data(w_out_data), .out_last(w_out_last),
    .full(w_full), .drop_err(w_drop_err), .sat_flag(w_sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N*AW-1:0] data;
    bit              last;
    int              idx;
  } row_t;

  logic [AW-1:0] mMem [D][N];
  int            mWp [N];
  bit            mDrain;
  row_t          sb[$];
  row_t          monRow;
  int            nVec = 0;
  int            nMis = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int r = 0; r < D; r++) begin
      for (int c = 0; c < N; c++) begin
        mMem[r][c] = '0;
      end
    end
    for (int c = 0; c < N; c++) begin
      mWp[c] = 0;
    end
    mDrain = 1'b0;
    sb.delete();
  endtask

  // One clock of stimulus on the main DUT, with the model updated for the
  // same cycle. Starting a drain snapshots every row into the scoreboard.
  task automatic drive_cycle(input logic [N-1:0] v, input logic [IW-1:0] d0,
                             input logic [IW-1:0] d1, input bit mode, input bit drain);
    logic [IW-1:0] dv [N];
    logic [AW-1:0] x;
    row_t          rw;
    dv[0] = d0;
    dv[1] = d1;
    in_valid    = v;
    in_data     = {d1, d0};
    acc_mode    = mode;
    drain_start = drain;
    if (!mDrain) begin
      for (int c = 0; c < N; c++) begin
        if (v[c]) begin
          x = {{(AW-IW){dv[c][IW-1]}}, dv[c]};
          mMem[mWp[c]][c] = mode ? (mMem[mWp[c]][c] + x) : x;
          mWp[c] = (mWp[c] + 1) % D;
        end
      end
      if (drain) begin
        mDrain = 1'b1;
        for (int r = 0; r < D; r++) begin
          rw.data = {mMem[r][1], mMem[r][0]};
          rw.last = (r == D - 1);
          rw.idx  = r;
          sb.push_back(rw);
        end
      end
    end
    tick();
    in_valid    = '0;
    drain_start = 1'b0;
    acc_mode    = 1'b0;
  endtask

  // Hold out_ready to a repeating 4-cycle pattern until the model sees the
  // last row accepted, with a cycle budget in case the DUT never finishes.
  task automatic run_drain(input bit [3:0] pat);
    int k;
    k = 0;
    while (mDrain && k < 64) begin
      out_ready = pat[k % 4];
      tick();
      k++;
    end
    out_ready = 1'b0;
    nVec++;
    if (mDrain) begin
      nMis++;
      $display("[TB] FAIL drain_timeout: got %0d rows still pending after %0d cycles, want 0", sb.size(), k);
      model_clear();
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    model_clear();
  endtask

  // Scoreboard consumer: every cycle a row is offered it must equal the
  // head of the queue; an accepted row is popped and zeroed in the model.
  always @(negedge clk) begin
    if (reset && out_valid) begin
      nVec++;
      if (sb.size() == 0) begin
        nMis++;
        $display("[TB] FAIL unexpected_row: got out_valid=1 data=%h, want no row", out_data);
      end else begin
        if (out_data !== sb[0].data || out_last !== sb[0].last) begin
          nMis++;
          $display("[TB] FAIL drain_row%0d: got data=%h last=%b, want data=%h last=%b",
                   sb[0].idx, out_data, out_last, sb[0].data, sb[0].last);
        end
        if (out_ready) begin
          monRow = sb.pop_front();
          for (int c = 0; c < N; c++) begin
            mMem[monRow.idx][c] = '0;
          end
          if (monRow.last) begin
            for (int c = 0; c < N; c++) begin
              mWp[c] = 0;
            end
            mDrain = 1'b0;
          end
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    nVec++; if (out_valid !== 1'b0) begin nMis++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    nVec++; if (out_last !== 1'b0) begin nMis++; $display("[TB] FAIL reset_out_last: got %b want 0", out_last); end
    nVec++; if (full !== 1'b0) begin nMis++; $display("[TB] FAIL reset_full: got %b want 0", full); end
    nVec++; if (drop_err !== 1'b0) begin nMis++; $display("[TB] FAIL reset_drop_err: got %b want 0", drop_err); end
    nVec++; if (sat_flag !== 2'b00) begin nMis++; $display("[TB] FAIL reset_sat_flag: got %b want 00", sat_flag); end
    nVec++; if (out_data !== '0) begin nMis++; $display("[TB] FAIL reset_out_data: got %h want 0", out_data); end
    nVec++; if (w_out_valid !== 1'b0) begin nMis++; $display("[TB] FAIL reset_wide_valid: got %b want 0", w_out_valid); end
    reset = 1'b1;
    model_clear();
    tick();
  endtask

  task automatic test_overwrite();
    for (int v = 1; v <= 4; v++) begin
      drive_cycle(2'b11, IW'(v), IW'(v), 1'b0, 1'b0);
      if (v == 3) begin
        nVec++; if (full !== 1'b0) begin nMis++; $display("[TB] FAIL ovw_full_early: got %b want 0", full); end
      end
    end
    nVec++; if (full !== 1'b1) begin nMis++; $display("[TB] FAIL ovw_full: got %b want 1", full); end
    drive_cycle(2'b00, '0, '0, 1'b0, 1'b1);
    nVec++; if (out_data !== {32'd1, 32'd1}) begin nMis++; $display("[TB] FAIL ovw_row0: got %h want %h", out_data, {32'd1, 32'd1}); end
    run_drain(4'b1111);
    nVec++; if (out_valid !== 1'b0) begin nMis++; $display("[TB] FAIL ovw_valid_drop: got %b want 0", out_valid); end
    nVec++; if (full !== 1'b0) begin nMis++; $display("[TB] FAIL ovw_full_clear: got %b want 0", full); end
    // Accumulating zeros onto the drained rows must read back zero.
    for (int v = 0; v < 4; v++) begin
      drive_cycle(2'b11, '0, '0, 1'b1, 1'b0);
    end
    nVec++; if (full !== 1'b1) begin nMis++; $display("[TB] FAIL zero_full: got %b want 1", full); end
    drive_cycle(2'b00, '0, '0, 1'b0, 1'b1);
    run_drain(4'b1111);
  endtask

  task automatic test_two_pass();
    for (int v = 0; v < 4; v++) drive_cycle(2'b11, 16'd5, 16'd5, 1'b0, 1'b0);
    for (int v = 0; v < 4; v++) drive_cycle(2'b11, 16'hFFF9, 16'hFFF9, 1'b1, 1'b0);
    drive_cycle(2'b11, 16'd0, 16'd0, 1'b0, 1'b0);
    drive_cycle(2'b00, '0, '0, 1'b0, 1'b1);
    nVec++; if (out_data !== 64'd0) begin nMis++; $display("[TB] FAIL twopass_zero_row0: got %h want 0", out_data); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    nVec++; if (out_data !== 64'hFFFFFFFE_FFFFFFFE) begin nMis++; $display("[TB] FAIL twopass_row1: got %h want fffffffefffffffe", out_data); end
    run_drain(4'b1111);
  endtask

  task automatic test_skew_backpressure();
    logic [N-1:0] v;
    for (int i = 0; i < 6; i++) begin
      v = {(i >= 2), (i <= 3)};
      drive_cycle(v, IW'(100 + i), IW'(200 + i), 1'b0, 1'b0);
      if (i == 4) begin
        nVec++; if (full !== 1'b0) begin nMis++; $display("[TB] FAIL skew_full_early: got %b want 0", full); end
      end
    end
    nVec++; if (full !== 1'b1) begin nMis++; $display("[TB] FAIL skew_full: got %b want 1", full); end
    drive_cycle(2'b00, '0, '0, 1'b0, 1'b1);
    run_drain(4'b1001);
    nVec++; if (out_valid !== 1'b0) begin nMis++; $display("[TB] FAIL skew_valid_drop: got %b want 0", out_valid); end
  endtask

  task automatic test_collision();
    for (int i = 0; i < 3; i++) drive_cycle(2'b11, IW'(30 + i), IW'(40 + i), 1'b0, 1'b0);
    drive_cycle(2'b11, 16'd33, 16'd43, 1'b0, 1'b1);
    nVec++; if (out_valid !== 1'b1) begin nMis++; $display("[TB] FAIL coll_drain_start: got %b want 1", out_valid); end
    nVec++; if (full !== 1'b1) begin nMis++; $display("[TB] FAIL coll_full: got %b want 1", full); end
    drive_cycle(2'b11, 16'd999, 16'd999, 1'b1, 1'b1);
    nVec++; if (drop_err !== 1'b1) begin nMis++; $display("[TB] FAIL coll_drop_err: got %b want 1", drop_err); end
    nVec++; if (out_data !== {32'd40, 32'd30}) begin nMis++; $display("[TB] FAIL coll_row0_kept: got %h want %h", out_data, {32'd40, 32'd30}); end
    run_drain(4'b1111);
    nVec++; if (drop_err !== 1'b1) begin nMis++; $display("[TB] FAIL coll_drop_sticky: got %b want 1", drop_err); end
    nVec++; if (out_valid !== 1'b0) begin nMis++; $display("[TB] FAIL coll_valid_drop: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_drain();
    for (int i = 0; i < 4; i++) drive_cycle(2'b11, 16'd3, 16'd3, 1'b0, 1'b0);
    drive_cycle(2'b00, '0, '0, 1'b0, 1'b1);
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    apply_reset();
    nVec++; if (out_valid !== 1'b0) begin nMis++; $display("[TB] FAIL rst_mid_valid: got %b want 0", out_valid); end
    nVec++; if (full !== 1'b0) begin nMis++; $display("[TB] FAIL rst_mid_full: got %b want 0", full); end
    nVec++; if (drop_err !== 1'b0) begin nMis++; $display("[TB] FAIL rst_mid_drop_err: got %b want 0", drop_err); end
    for (int i = 0; i < 4; i++) drive_cycle(2'b11, 16'd9, 16'd9, 1'b0, 1'b0);
    drive_cycle(2'b00, '0, '0, 1'b0, 1'b1);
    nVec++; if (out_data !== {32'd9, 32'd9}) begin nMis++; $display("[TB] FAIL rst_mid_refill: got %h want %h", out_data, {32'd9, 32'd9}); end
    run_drain(4'b1111);
  endtask

  task automatic test_saturate();
    logic [N*AW-1:0] expRow;
    logic [N-1:0]    expSat;
`ifdef ACCUMULATOR_BANK_SATURATE_EN
    expRow = {32'h80000000, 32'h7FFFFFFF};
    expSat = 2'b11;
`else
    expRow = {32'h7FFFFF10, 32'h800000F0};
    expSat = 2'b00;
`endif
    w_in_valid = 2'b11;
    w_acc_mode = 1'b0;
    w_in_data  = {32'h80000010, 32'h7FFFFFF0};
    for (int i = 0; i < 4; i++) tick();
    w_acc_mode = 1'b1;
    w_in_data  = {32'hFFFFFF00, 32'h00000100};
    for (int i = 0; i < 4; i++) tick();
    w_in_valid = '0;
    w_acc_mode = 1'b0;
    nVec++; if (w_sat_flag !== expSat) begin nMis++; $display("[TB] FAIL sat_flag_set: got %b want %b", w_sat_flag, expSat); end
    w_drain_start = 1'b1;
    tick();
    w_drain_start = 1'b0;
    w_out_ready   = 1'b1;
    for (int r = 0; r < D; r++) begin
      nVec++;
      if (w_out_valid !== 1'b1 || w_out_data !== expRow || w_out_last !== (r == D - 1)) begin
        nMis++;
        $display("[TB] FAIL sat_row%0d: got valid=%b data=%h last=%b, want valid=1 data=%h last=%b",
                 r, w_out_valid, w_out_data, w_out_last, expRow, (r == D - 1));
      end
      tick();
    end
    w_out_ready = 1'b0;
    nVec++; if (w_out_valid !== 1'b0) begin nMis++; $display("[TB] FAIL sat_valid_drop: got %b want 0", w_out_valid); end
    nVec++; if (w_sat_flag !== 2'b00) begin nMis++; $display("[TB] FAIL sat_flag_clear: got %b want 00", w_sat_flag); end
  endtask

  initial begin
    reset         = 1'b0;
    in_valid      = '0;
    in_data       = '0;
    acc_mode      = 1'b0;
    drain_start   = 1'b0;
    out_ready     = 1'b0;
    w_in_valid    = '0;
    w_in_data     = '0;
    w_acc_mode    = 1'b0;
    w_drain_start = 1'b0;
    w_out_ready   = 1'b0;
    model_clear();
    test_reset();
    test_overwrite();
    test_two_pass();
    test_skew_backpressure();
    test_collision();
    test_reset_mid_drain();
    test_saturate();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no completion, want $finish before 200000ns");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
